// File: rtl/ss_seq.sv
// rtl/ss_seq.sv - save-state sequencer: walks the mapper save-state port to copy registers to/from a snapshot buffer
module ss_seq #(
    parameter int SS_LAST = 127,
    parameter int SETTLE  = 2,
    parameter int TMO     = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m2,
    input  logic       start,
    input  logic       dir,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] buf_addr,
    output logic       buf_re,
    input  logic [7:0] buf_rdat,
    output logic       buf_we,
    output logic [7:0] buf_wdat
);

    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [3:0] {
        IDLE, ARM, S_ADDR, S_WAIT, S_CAP, L_FETCH, L_LATCH, L_WAIT, L_HOLD, NEXT, FIN
    } state_t;

    state_t        state_q, state_d;
    logic          dir_q, dir_d;
    logic          err_q, err_d;
    logic [7:0]    addr_q, addr_d;
    logic [3:0]    settle_q, settle_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    wdat_q, wdat_d;
    logic          m2_s1_q, m2_s2_q, m2_dly_q;
    logic          m2_fall;
    logic          tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m2_s1_q  <= 1'b0;
            m2_s2_q  <= 1'b0;
            m2_dly_q <= 1'b0;
        end else begin
            m2_s1_q  <= m2;
            m2_s2_q  <= m2_s1_q;
            m2_dly_q <= m2_s2_q;
        end
    end

    assign m2_fall = m2_dly_q & ~m2_s2_q;
    assign tmo_hit = (tmo_q == TW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            wdat_q   <= wdat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        err_d    = err_q;
        addr_d   = addr_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        wdat_d   = wdat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    err_d   = 1'b0;
                    addr_d  = '0;
                    tmo_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (m2_fall) begin
                    state_d = dir_q ? L_FETCH : S_ADDR;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_ADDR: begin
                settle_d = 4'(SETTLE - 1);
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (settle_q == 4'd0) state_d = S_CAP;
                else                  settle_d = settle_q - 4'd1;
            end
            S_CAP:   state_d = NEXT;
            L_FETCH: state_d = L_LATCH;
            L_LATCH: begin
                wdat_d  = buf_rdat;
                tmo_d   = '0;
                state_d = L_WAIT;
            end
            L_WAIT: begin
                // A fall seen on the first ss_we cycle may predate the write request.
                if (m2_fall && tmo_q != '0) begin
                    state_d = L_HOLD;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            L_HOLD: state_d = NEXT;
            NEXT: begin
                if (abort || addr_q == 8'(SS_LAST)) begin
                    state_d = FIN;
                end else begin
                    addr_d  = addr_q + 8'd1;
                    state_d = dir_q ? L_FETCH : S_ADDR;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE) && (state_q != FIN);
    assign ss_act   = busy;
    assign done     = (state_q == FIN);
    assign err      = err_q;
    assign ss_we    = (state_q == L_WAIT) || (state_q == L_HOLD);
    assign ss_addr  = addr_q;
    assign buf_addr = addr_q;
    assign ss_wdat  = wdat_q;
    assign buf_re   = (state_q == L_FETCH);
    assign buf_we   = (state_q == S_CAP);
    assign buf_wdat = (state_q == S_CAP) ? ss_rdat : 8'h00;

endmodule

// File: tb/tb_ss_seq.sv
// tb/tb_ss_seq.sv - directed self-checking bench for ss_seq with mapper and snapshot buffer models
module tb_ss_seq;

    logic       clk = 1'b0, rst_n = 1'b0, m2 = 1'b0;
    logic       start = 1'b0, dir = 1'b0, abort = 1'b0;
    logic       busy, done, err, ss_act, ss_we, buf_re, buf_we;
    logic [7:0] ss_addr, ss_wdat, ss_rdat, buf_addr, buf_wdat;
    logic [7:0] buf_rdat = 8'h00;
    logic [38:0] outs;

    int checks = 0, failures = 0;
    logic [7:0] mreg [256];
    logic [7:0] bufm [256];
    int n_buf_we, n_done, n_mwr, order_err, we_run, we_run_last;
    logic [7:0] last_we_addr;
    bit m2_run = 1'b0;

    ss_seq #(.SS_LAST(127), .SETTLE(2), .TMO(64)) dut (
        .clk(clk), .rst_n(rst_n), .m2(m2), .start(start), .dir(dir), .abort(abort),
        .busy(busy), .done(done), .err(err), .ss_act(ss_act), .ss_we(ss_we),
        .ss_addr(ss_addr), .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
        .buf_addr(buf_addr), .buf_re(buf_re), .buf_rdat(buf_rdat),
        .buf_we(buf_we), .buf_wdat(buf_wdat)
    );

    assign outs = {busy, done, err, ss_act, ss_we, buf_re, buf_we, ss_addr, buf_addr, ss_wdat, buf_wdat};
    assign ss_rdat = mreg[ss_addr];

    always #5 clk = ~clk;

    initial begin
        #3;
        forever begin
            #60;
            if (m2_run) m2 = ~m2;
        end
    end

    always @(posedge clk) begin
        if (buf_we) bufm[buf_addr] <= buf_wdat;
        if (buf_re) buf_rdat <= bufm[buf_addr];
    end

    always @(negedge m2) begin
        if (ss_act && ss_we) begin
            mreg[ss_addr] = ss_wdat;
            n_mwr = n_mwr + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (buf_we) begin
                if (buf_addr !== 8'(n_buf_we)) order_err = order_err + 1;
                last_we_addr = buf_addr;
                n_buf_we = n_buf_we + 1;
            end
            if (done) n_done = n_done + 1;
            if (ss_we) we_run = we_run + 1;
            else if (we_run > 0) begin
                we_run_last = we_run;
                we_run = 0;
            end
        end
    end

    task automatic clr_counters();
        n_buf_we = 0; n_done = 0; n_mwr = 0; order_err = 0;
        we_run = 0; we_run_last = 0; last_we_addr = 8'h00;
    endtask

    task automatic pulse_start(input logic d, input logic a);
        @(negedge clk);
        start = 1'b1; dir = d; abort = a;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (n_done > 0) break;
        end
        checks++;
        if (n_done == 0) begin
            failures++;
            $display("FAIL %s_done_timeout: done=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (outs !== 39'h0) begin failures++; $display("FAIL reset_outs: got %h required 0", outs); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (outs !== 39'h0) begin failures++; $display("FAIL idle_outs: got %h required 0", outs); end
    endtask

    task automatic test_save();
        for (int i = 0; i < 256; i++) begin mreg[i] = 8'hFF; bufm[i] = 8'h00; end
        mreg[0] = 8'h02; mreg[127] = 8'h5A;
        clr_counters();
        m2_run = 1'b0; m2 = 1'b1;
        pulse_start(1'b0, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || ss_act !== 1'b1 || n_buf_we != 0) begin
            failures++;
            $display("FAIL save_arm_wait: busy=%b ss_act=%b buf_we_count=%0d required 1 1 0", busy, ss_act, n_buf_we);
        end
        m2_run = 1'b1;
        wait_done(2000, "save");
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (n_buf_we != 128) begin failures++; $display("FAIL save_count: got %0d required 128", n_buf_we); end
        checks++;
        if (order_err != 0) begin failures++; $display("FAIL save_order: got %0d out-of-order writes required 0", order_err); end
        checks++;
        if (bufm[0] !== 8'h02) begin failures++; $display("FAIL save_buf0: got %h required 02", bufm[0]); end
        checks++;
        if (bufm[127] !== 8'h5A) begin failures++; $display("FAIL save_buf127: got %h required 5a", bufm[127]); end
        checks++;
        if (bufm[64] !== 8'hFF) begin failures++; $display("FAIL save_buf64: got %h required ff", bufm[64]); end
        checks++;
        if (n_done != 1 || err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL save_end: done_count=%0d err=%b busy=%b required 1 0 0", n_done, err, busy);
        end
    endtask

    task automatic test_load();
        int mism;
        for (int i = 0; i < 256; i++) begin mreg[i] = 8'h00; bufm[i] = 8'(i * 5 + 3); end
        bufm[0] = 8'h01;
        clr_counters();
        pulse_start(1'b1, 1'b0);
        wait_done(4000, "load");
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL load_fin: done=%b busy=%b required 1 0", done, busy); end
        @(negedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL load_after: done=%b busy=%b required 0 0", done, busy); end
        checks++;
        if (mreg[0] !== 8'h01) begin failures++; $display("FAIL load_reg0: got %h required 01", mreg[0]); end
        mism = 0;
        for (int i = 0; i < 128; i++) if (mreg[i] !== bufm[i]) mism++;
        checks++;
        if (mism != 0) begin failures++; $display("FAIL load_regs: got %0d mismatching registers required 0", mism); end
        checks++;
        if (n_mwr != 128 || n_done != 1) begin
            failures++;
            $display("FAIL load_counts: writes=%0d done_count=%0d required 128 1", n_mwr, n_done);
        end
    endtask

    task automatic test_timeout();
        clr_counters();
        m2_run = 1'b1;
        pulse_start(1'b1, 1'b0);
        for (int i = 0; i < 400 && n_mwr < 2; i++) @(negedge clk);
        for (int i = 0; i < 40 && m2 !== 1'b0; i++) @(negedge clk);
        m2_run = 1'b0; m2 = 1'b0;
        wait_done(4000, "tmo");
        checks++;
        if (we_run_last != 64) begin failures++; $display("FAIL tmo_len: ss_we high %0d cycles required 64", we_run_last); end
        checks++;
        if (err !== 1'b1 || ss_we !== 1'b0 || ss_act !== 1'b0) begin
            failures++;
            $display("FAIL tmo_flags: err=%b ss_we=%b ss_act=%b required 1 0 0", err, ss_we, ss_act);
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || n_done != 1) begin
            failures++;
            $display("FAIL tmo_sticky: err=%b done_count=%0d required 1 1", err, n_done);
        end
        m2_run = 1'b1;
        clr_counters();
        pulse_start(1'b0, 1'b0);
        #1;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL tmo_clear: err=%b busy=%b required 0 1", err, busy); end
        wait_done(2000, "tmo_clear");
    endtask

    task automatic test_abort();
        clr_counters();
        pulse_start(1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy && ss_addr == 8'd5) begin abort = 1'b1; break; end
        end
        wait_done(400, "abort");
        abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (n_buf_we != 6 || last_we_addr !== 8'd5 || order_err != 0) begin
            failures++;
            $display("FAIL abort_stop: writes=%0d last=%0d order_err=%0d required 6 5 0", n_buf_we, last_we_addr, order_err);
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        clr_counters();
        seen = 1'b0;
        pulse_start(1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ss_we === 1'b1) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rst_we_seen: ss_we=0 required 1"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 39'h0) begin failures++; $display("FAIL rst_async: got %h required 0", outs); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || ss_act !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL rst_idle: busy=%b ss_act=%b err=%b required 0 0 0", busy, ss_act, err);
        end
    endtask

    task automatic test_back_to_back();
        clr_counters();
        pulse_start(1'b0, 1'b0);
        repeat (10) @(negedge clk);
        pulse_start(1'b1, 1'b0);
        wait_done(2000, "b2b");
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (n_done != 1 || n_buf_we != 128 || n_mwr != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignore: done_count=%0d writes=%0d mapper_writes=%0d busy=%b required 1 128 0 0",
                     n_done, n_buf_we, n_mwr, busy);
        end
        clr_counters();
        pulse_start(1'b0, 1'b1);
        wait_done(2000, "start_abort");
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (n_done != 1 || n_buf_we != 128) begin
            failures++;
            $display("FAIL start_abort: done_count=%0d writes=%0d required 1 128", n_done, n_buf_we);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mreg[i] = 8'h00; bufm[i] = 8'h00; end
        clr_counters();
        test_reset();
        test_save();
        test_load();
        test_timeout();
        test_abort();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Save-state sequencer for the mapper register file.
- Walks the mapper's save-state port (ss_act/ss_we/ss_addr, write data on the cpu_dat path, read data on ss_rdat) over a contiguous address range.
- Save: copies every register into an external snapshot buffer. Load: restores every register from that buffer.
- Sits between the host/menu logic and the mapper core. Owns the save-state port for the whole operation, so the mapper's register writes only ever happen on an m2 falling edge.

Parameters:
- SS_LAST, 127, last save-state address visited; the range walked is 0..SS_LAST.
- SETTLE, 2, clk cycles the address is held before ss_rdat is sampled; valid range 1..15.
- TMO, 4096, clk cycles allowed for an m2 falling edge before the operation aborts with an error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- m2  in  1  CPU phase, asynchronous to clk.
- start  in  1  one-cycle command strobe; ignored while busy.
- dir  in  1  sampled with start: 0 = save, 1 = load.
- abort  in  1  level; honoured at entry boundary only.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse at end of operation.
- err  out  1  sticky m2-timeout flag; cleared by start.
- ss_act  out  1  save-state mode to mapper.
- ss_we  out  1  save-state write enable.
- ss_addr  out  8  save-state address.
- ss_wdat  out  8  write data, muxed onto cpu_dat while ss_act.
- ss_rdat  in  8  mapper read-back.
- buf_addr  out  8  snapshot buffer address; equals ss_addr.
- buf_re  out  1  buffer read strobe; 1-cycle read latency.
- buf_rdat  in  8  buffer read data.
- buf_we  out  1  buffer write strobe.
- buf_wdat  out  8  buffer write data.

Interface: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset:
  - Asynchronous on rst_n low.
  - All outputs 0, FSM to IDLE, address counter 0, err 0.
  - Reset mid-write drops ss_we immediately; the mapper register may be left unwritten, which is acceptable.
- m2 synchronisation:
  - 2-FF synchroniser on m2, plus a one-cycle delayed copy.
  - m2_fall = delayed copy high and synchronised value low.
- FSM states: IDLE, ARM, S_ADDR, S_WAIT, S_CAP, L_FETCH, L_LATCH, L_WAIT, L_HOLD, NEXT, FIN.
- IDLE:
  - start=1: latch dir, clear err, address 0, busy=1, ss_act=1, go to ARM.
- ARM:
  - Wait for the first m2_fall, so that any CPU write in flight completes before the sequence begins.
  - Then go to S_ADDR (dir=0) or L_FETCH (dir=1).
- Save path:
  - S_ADDR: present ss_addr, load the settle counter.
  - S_WAIT: count SETTLE cycles.
  - S_CAP: buf_we=1 for one cycle, buf_wdat=ss_rdat.
  - Then NEXT.
  - Save never waits on m2 after ARM.
- Load path:
  - L_FETCH: buf_re=1 for one cycle.
  - L_LATCH: register buf_rdat into ss_wdat.
  - L_WAIT: ss_we=1 until m2_fall.
  - L_HOLD: one cycle with ss_we=1 and ss_wdat stable, then ss_we=0.
  - Then NEXT.
- NEXT:
  - If abort=1 or address==SS_LAST, go to FIN.
  - Otherwise increment the address (8-bit, no wrap past SS_LAST) and return to S_ADDR or L_FETCH.
- FIN:
  - ss_act=0, busy=0, done=1 for exactly one cycle, go to IDLE.
- Timeout:
  - Counter is cleared on entry to ARM and to L_WAIT.
  - If it reaches TMO before m2_fall: err=1, ss_we=0, go to FIN.
- Simultaneous events:
  - start while busy: ignored, no queueing.
  - abort together with start in IDLE: start wins; abort is only sampled in NEXT.
  - m2_fall on the same cycle ss_we first rises: it does not count; the block waits for the next fall.
- Fixed outputs:
  - buf_addr always equals ss_addr.
  - ss_wdat holds its last value when not in use.

Test Plan:
- Save, SS_LAST=127, mapper chr=2'b10: start, dir=0 → ARM waits for one m2_fall; buf_we pulses 128 times at addresses 0..127. Buffer holds 0x02 at address 0 and the map_idx value at 127; 0xFF elsewhere; done pulses once.
- Load with buf[0]=0x01: start, dir=1 → ss_we held across an m2_fall at ss_addr=0, ss_wdat=0x01, mapper chr becomes 2'b01. 128 write cycles; done pulses once; busy low the cycle after done.
- m2 stuck low during load with TMO=64 → err=1 after 64 cycles, ss_we=0, done pulses, ss_act=0. A following start clears err.
- abort asserted during the save of entry 5 → entry 5 completes (buf_we seen at address 5); FIN follows; no buf_we at address 6.
- rst_n pulled low while ss_we=1 → all outputs 0 the same cycle. After release, the block is in IDLE and start works normally.
- start pulsed while busy, and start/abort together in IDLE → second start ignored (single done); start+abort runs a full operation.
